// File: rtl/serial_adder_if.sv
// -----------------------------------------------------------------------------
// serial_adder_if
//   Request/result bundle for the bit-serial adder.
//   master : drives start, a, b, cin; observes busy, done, sum, cout
//   slave  : the adder side of the same signals
//   WIDTH  : operand / sum width in bits, must match the attached adder
// -----------------------------------------------------------------------------
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Adds two WIDTH-bit operands plus a carry-in one bit per clock, LSB first,
//   through a single full-adder cell and a registered carry. A start request
//   loads the operands; WIDTH cycles later the registered sum and carry-out
//   are published together with a one-cycle done pulse.
//
//   Ports:
//     clk        rising-edge clock
//     reset      asynchronous, active-high reset
//     bus.start  request, sampled with a/b/cin on the rising edge (IDLE/DONE)
//     bus.a/b    operands
//     bus.cin    carry-in
//     bus.busy   high while in RUN
//     bus.done   one-cycle pulse in DONE; sum/cout valid
//     bus.sum    registered result, held until the next completion
//     bus.cout   registered carry-out, held with sum
// -----------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  serial_adder_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic             r_c;
  logic [WIDTH-1:0] r_r;
  logic [CW-1:0]    r_n;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_s;
  logic             w_c;
  logic             w_last;
  logic             w_load;
  logic             w_run;

  // Single full-adder cell on the current LSBs and the running carry.
  always_comb begin
    w_s = r_sa[0] ^ r_sb[0] ^ r_c;
    w_c = (r_sa[0] & r_sb[0]) | (r_c & (r_sa[0] ^ r_sb[0]));
  end

  always_comb begin
    w_run  = (r_state == S_RUN);
    w_last = w_run && (r_n == CW'(WIDTH - 1));
    // start is only honoured outside RUN; a request during RUN is dropped.
    w_load = (r_state != S_RUN) && bus.start;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE,
      S_DONE:  w_next = bus.start ? S_RUN : S_IDLE;
      S_RUN:   w_next = w_last ? S_DONE : S_RUN;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand / carry / partial-result datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sa <= '0;
      r_sb <= '0;
      r_c  <= 1'b0;
      r_r  <= '0;
      r_n  <= '0;
    end else if (w_load) begin
      r_sa <= bus.a;
      r_sb <= bus.b;
      r_c  <= bus.cin;
      r_r  <= '0;
      r_n  <= '0;
    end else if (w_run) begin
      r_sa <= {1'b0, r_sa[WIDTH-1:1]};
      r_sb <= {1'b0, r_sb[WIDTH-1:1]};
      r_c  <= w_c;
      r_r  <= {w_s, r_r[WIDTH-1:1]};
      r_n  <= r_n + 1'b1;
    end
  end

  // Published result: only the completion edge updates it, so the previous
  // result stays visible throughout the next RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else if (w_last) begin
      r_sum  <= {w_s, r_r[WIDTH-1:1]};
      r_cout <= w_c;
    end
  end

  // Status decoded from the registered state only.
  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    bus.sum  = r_sum;
    bus.cout = r_cout;
    if (r_state == S_RUN)  bus.busy = 1'b1;
    if (r_state == S_DONE) bus.done = 1'b1;
  end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  localparam int W = 8;

  logic clk;
  logic reset;

  int vectors     = 0;
  int miscompares = 0;

  // Expected currently-held result (from the model, not from the DUT).
  logic [W-1:0] p_sum;
  logic         p_cout;

  // Per-cycle observations: index k = negedge following edge E_k.
  logic         obs_busy [0:31];
  logic         obs_done [0:31];
  logic [W-1:0] obs_sum  [0:31];
  logic         obs_cout [0:31];

  serial_adder_if #(.WIDTH(W)) bus8 ();
  serial_adder_if #(.WIDTH(2)) bus2 ();

  serial_adder #(.WIDTH(W)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8.slave)
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  // Reference: exact (WIDTH+1)-bit sum.
  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  endfunction

  // Drive one request on the 8-bit DUT and record outputs for ncyc cycles.
  task automatic launch8(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input int ncyc);
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = a; bus8.b = b; bus8.cin = cin;
    @(posedge clk);
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      if (k == 0) bus8.start = 1'b0;
      obs_busy[k] = bus8.busy;
      obs_done[k] = bus8.done;
      obs_sum[k]  = bus8.sum;
      obs_cout[k] = bus8.cout;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
    bus2.start = 1'b0; bus2.a = '0; bus2.b = '0; bus2.cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({bus8.busy, bus8.done, bus8.sum, bus8.cout} !== {2'b00, {W{1'b0}}, 1'b0}) begin
      miscompares++;
      $display("FAIL reset8: busy=%b done=%b sum=%h cout=%b, want all zero",
               bus8.busy, bus8.done, bus8.sum, bus8.cout);
    end
    vectors++;
    if ({bus2.busy, bus2.done, bus2.sum, bus2.cout} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset2: busy=%b done=%b sum=%h cout=%b, want all zero",
               bus2.busy, bus2.done, bus2.sum, bus2.cout);
    end
    @(negedge clk);
    reset = 1'b0;
    p_sum = '0; p_cout = 1'b0;
  endtask

  // One request with full timing and hold checks.
  task automatic test_basic(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    logic [W:0] exp;
    exp = ref_add(a, b, cin);
    launch8(a, b, cin, W + 2);
    for (int k = 0; k < W + 2; k++) begin
      vectors++;
      if (obs_busy[k] !== (k < W) || obs_done[k] !== (k == W)) begin
        miscompares++;
        $display("FAIL basic_status a=%h b=%h k=%0d: busy=%b done=%b, want busy=%b done=%b",
                 a, b, k, obs_busy[k], obs_done[k], k < W, k == W);
      end
      vectors++;
      if (k < W) begin
        if (obs_sum[k] !== p_sum || obs_cout[k] !== p_cout) begin
          miscompares++;
          $display("FAIL basic_hold k=%0d: sum=%h cout=%b, want sum=%h cout=%b",
                   k, obs_sum[k], obs_cout[k], p_sum, p_cout);
        end
      end else if ({obs_cout[k], obs_sum[k]} !== exp) begin
        miscompares++;
        $display("FAIL basic_result a=%h b=%h cin=%b k=%0d: sum=%h cout=%b, want sum=%h cout=%b",
                 a, b, cin, k, obs_sum[k], obs_cout[k], exp[W-1:0], exp[W]);
      end
    end
    p_sum = exp[W-1:0]; p_cout = exp[W];
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++) begin
      test_basic(W'($urandom), W'($urandom), 1'($urandom));
    end
  endtask

  // A second start during RUN must not restart or re-sample operands.
  task automatic test_ignore_start;
    logic [W:0] exp;
    exp = ref_add(8'h11, 8'h22, 1'b0);
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'h11; bus8.b = 8'h22; bus8.cin = 1'b0;
    @(posedge clk);
    for (int k = 0; k < W + 3; k++) begin
      @(negedge clk);
      if (k == 0) bus8.start = 1'b0;
      if (k == 2) begin bus8.start = 1'b1; bus8.a = 8'hFF; bus8.b = 8'hFF; end
      if (k == 3) bus8.start = 1'b0;
      vectors++;
      if (bus8.busy !== (k < W) || bus8.done !== (k == W)) begin
        miscompares++;
        $display("FAIL ignore_status k=%0d: busy=%b done=%b, want busy=%b done=%b",
                 k, bus8.busy, bus8.done, k < W, k == W);
      end
      vectors++;
      if (k < W) begin
        if (bus8.sum !== p_sum || bus8.cout !== p_cout) begin
          miscompares++;
          $display("FAIL ignore_hold k=%0d: sum=%h cout=%b, want sum=%h cout=%b",
                   k, bus8.sum, bus8.cout, p_sum, p_cout);
        end
      end else if ({bus8.cout, bus8.sum} !== exp) begin
        miscompares++;
        $display("FAIL ignore_result k=%0d: sum=%h cout=%b, want sum=%h cout=%b",
                 k, bus8.sum, bus8.cout, exp[W-1:0], exp[W]);
      end
    end
    p_sum = exp[W-1:0]; p_cout = exp[W];
  endtask

  // start held high: one result every W+1 cycles, done one cycle wide.
  task automatic test_hold_start;
    logic [W:0] exp;
    bit         idle;
    exp = ref_add(8'h80, 8'h80, 1'b1);
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'h80; bus8.b = 8'h80; bus8.cin = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 3 * (W + 1); k++) begin
      @(negedge clk);
      vectors++;
      if (bus8.done !== ((k % (W + 1)) == W) || bus8.busy !== ((k % (W + 1)) != W)) begin
        miscompares++;
        $display("FAIL hold_status k=%0d: busy=%b done=%b, want busy=%b done=%b",
                 k, bus8.busy, bus8.done, (k % (W + 1)) != W, (k % (W + 1)) == W);
      end
      if ((k % (W + 1)) == W) begin
        vectors++;
        if ({bus8.cout, bus8.sum} !== exp) begin
          miscompares++;
          $display("FAIL hold_result k=%0d: sum=%h cout=%b, want sum=%h cout=%b",
                   k, bus8.sum, bus8.cout, exp[W-1:0], exp[W]);
        end
      end
    end
    bus8.start = 1'b0;
    idle = 1'b0;
    for (int i = 0; i < 3 * W && !idle; i++) begin
      @(negedge clk);
      idle = !bus8.busy && !bus8.done;
    end
    vectors++;
    if (!idle) begin
      miscompares++;
      $display("FAIL hold_drain: busy=%b done=%b, want idle within %0d cycles",
               bus8.busy, bus8.done, 3 * W);
    end
    p_sum = exp[W-1:0]; p_cout = exp[W];
  endtask

  // New random operands presented in each DONE cycle with start held.
  task automatic test_back_to_back(input int nops);
    logic [W:0] expq[$];
    logic [W-1:0] a, b;
    logic         c;
    logic [W:0]   e;
    a = W'($urandom); b = W'($urandom); c = 1'($urandom);
    expq.push_back(ref_add(a, b, c));
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = a; bus8.b = b; bus8.cin = c;
    @(posedge clk);
    for (int k = 0; k < nops * (W + 1); k++) begin
      @(negedge clk);
      if ((k % (W + 1)) == W) begin
        e = expq.pop_front();
        vectors++;
        if (bus8.done !== 1'b1 || {bus8.cout, bus8.sum} !== e) begin
          miscompares++;
          $display("FAIL b2b_result k=%0d: done=%b sum=%h cout=%b, want done=1 sum=%h cout=%b",
                   k, bus8.done, bus8.sum, bus8.cout, e[W-1:0], e[W]);
        end
        p_sum = e[W-1:0]; p_cout = e[W];
        if (k / (W + 1) < nops - 1) begin
          a = W'($urandom); b = W'($urandom); c = 1'($urandom);
          expq.push_back(ref_add(a, b, c));
          bus8.a = a; bus8.b = b; bus8.cin = c;
        end else begin
          bus8.start = 1'b0;
        end
      end else begin
        vectors++;
        if (bus8.busy !== 1'b1 || bus8.done !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b_status k=%0d: busy=%b done=%b, want busy=1 done=0",
                   k, bus8.busy, bus8.done);
        end
      end
    end
    @(negedge clk);
    vectors++;
    if (bus8.busy !== 1'b0 || bus8.done !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_idle: busy=%b done=%b, want 0 0", bus8.busy, bus8.done);
    end
  endtask

  // Asynchronous reset between E4 and E5 of an operation.
  task automatic test_async_reset;
    test_basic(8'h3C, 8'h42, 1'b0);
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'hC3; bus8.b = 8'h5D; bus8.cin = 1'b1;
    @(posedge clk);
    #1 bus8.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    vectors++;
    if (bus8.busy !== 1'b1 || bus8.sum !== 8'h7E || bus8.cout !== 1'b0) begin
      miscompares++;
      $display("FAIL arst_pre: busy=%b sum=%h cout=%b, want busy=1 sum=7e cout=0",
               bus8.busy, bus8.sum, bus8.cout);
    end
    #1 reset = 1'b1;
    #1;
    vectors++;
    if ({bus8.busy, bus8.done, bus8.sum, bus8.cout} !== {2'b00, {W{1'b0}}, 1'b0}) begin
      miscompares++;
      $display("FAIL arst_immediate: busy=%b done=%b sum=%h cout=%b, want all zero",
               bus8.busy, bus8.done, bus8.sum, bus8.cout);
    end
    @(negedge clk);
    reset = 1'b0;
    p_sum = '0; p_cout = 1'b0;
    test_basic(8'h9A, 8'h77, 1'b1);
  endtask

  // Exhaustive sweep on the 2-bit instance.
  task automatic test_width2;
    logic [4:0] v;
    logic [2:0] exp;
    logic       ok;
    for (int i = 0; i < 32; i++) begin
      v = 5'(i);
      exp = {1'b0, v[1:0]} + {1'b0, v[3:2]} + {2'b00, v[4]};
      @(negedge clk);
      bus2.start = 1'b1; bus2.a = v[1:0]; bus2.b = v[3:2]; bus2.cin = v[4];
      @(posedge clk);
      ok = 1'b1;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        if (k == 0) bus2.start = 1'b0;
        if (bus2.busy !== (k < 2) || bus2.done !== (k == 2)) ok = 1'b0;
        if (k == 2 && {bus2.cout, bus2.sum} !== exp) ok = 1'b0;
      end
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("FAIL w2 a=%0d b=%0d cin=%b: done=%b sum=%0d cout=%b, want done at E2 with sum=%0d cout=%b",
                 v[1:0], v[3:2], v[4], bus2.done, bus2.sum, bus2.cout, exp[1:0], exp[2]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic(8'h00, 8'h00, 1'b0);
    test_basic(8'hFF, 8'h01, 1'b0);
    test_basic(8'hA5, 8'h5A, 1'b1);
    test_basic(8'h3C, 8'h42, 1'b0);
    test_ignore_start();
    test_hold_start();
    test_random(12);
    test_back_to_back(6);
    test_async_reset();
    test_width2();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
